// File: rtl/apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_bridge : valid/ready command stream to single APB transfers
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  PSELx,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);
   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic             TMO_EN   = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic                    psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;
   logic                    rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    cmd_accept;

   assign cmd_ready  = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
   assign cmd_accept = cmd_valid && cmd_ready;

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;

      case (state_q)
         S_IDLE: ;
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               state_d       = S_RESP;
            end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
               // This edge closes the last permitted wait cycle.
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Acceptance is only possible in IDLE or in RESP while the response drains.
      if (cmd_accept) begin
         pwrite_d  = cmd_write;
         paddr_d   = cmd_addr;
         pwdata_d  = cmd_wdata;
         psel_d    = 1'b1;
         penable_d = 1'b0;
         cnt_d     = '0;
         state_d   = S_SETUP;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q       <= S_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign PSELx       = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_master_bridge : self-checking bench for apb_master_bridge
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;
   localparam int TMO = 4;

   logic        PCLK = 1'b0, PRESET = 1'b1;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0, PRDATA = '0;
   logic        PREADY = 1'b0, PSLVERR = 1'b0;
   logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
   logic        PSELx, PENABLE, PWRITE;
   logic [31:0] rsp_rdata, PADDR, PWDATA;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        ok_accept;
      int          setup;
      int          access;
      int          latency;
      logic        stable;
      logic        pen_bad;
      logic [1:0]  bus_at_rsp;
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      logic        cmdrdy_at_rsp;
   } obs_t;

   apb_master_bridge #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PSELx       (PSELx),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Content the modelled responder returns for a given address.
   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
   endfunction

   // Issue one command and act as an APB responder that inserts 'waits' wait
   // states; the response is left pending with rsp_ready low.
   task automatic drive_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input int waits, input logic [31:0] prd, input logic serr,
                             output obs_t o);
      o.setup = 0; o.access = 0; o.latency = -1; o.stable = 1'b1; o.pen_bad = 1'b0;
      o.bus_at_rsp = 2'b11; o.rdata = '0; o.err = 1'b0; o.tmo = 1'b0; o.cmdrdy_at_rsp = 1'b1;
      @(negedge PCLK);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b0;
      #1 o.ok_accept = cmd_ready;
      @(posedge PCLK);
      #1 cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge PCLK);
         if (rsp_valid) begin
            o.latency = cyc; o.bus_at_rsp = {PSELx, PENABLE}; o.rdata = rsp_rdata;
            o.err = rsp_err; o.tmo = rsp_timeout; o.cmdrdy_at_rsp = cmd_ready;
            break;
         end
         if (PENABLE && !PSELx) o.pen_bad = 1'b1;
         if (PSELx && (PADDR !== a || PWRITE !== wr || PWDATA !== d)) o.stable = 1'b0;
         if (PSELx && !PENABLE) o.setup = o.setup + 1;
         if (PSELx && PENABLE) begin
            o.access = o.access + 1;
            PREADY   = (o.access == waits + 1);
         end else begin
            PREADY = 1'($urandom);
         end
         PRDATA  = (PREADY && PSELx && PENABLE) ? prd  : $urandom;
         PSLVERR = (PREADY && PSELx && PENABLE) ? serr : 1'($urandom);
      end
   endtask

   task automatic consume(input int delay);
      repeat (delay) @(negedge PCLK);
      @(negedge PCLK);
      rsp_ready = 1'b1;
      @(posedge PCLK);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      repeat (2) @(posedge PCLK);
      #1;
      n_checks++;
      if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h rsp_valid=%b expected all zero",
                            PSELx, PENABLE, PADDR, rsp_valid);
      end
      @(negedge PCLK);
      PRESET = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h55; PREADY = 1'b0;
      @(posedge PCLK);
      #1 cmd_valid = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      n_checks++;
      if ({PSELx, PENABLE} !== 2'b11) begin
         n_fail++; $display("FAIL reset_reach_access: got psel/pen=%b expected 11", {PSELx, PENABLE});
      end
      PRESET = 1'b1;
      @(negedge PCLK);
      @(negedge PCLK);
      PRESET = 1'b0;
      #1;
      n_checks++;
      if ({PSELx, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
         n_fail++; $display("FAIL reset_midaccess: got psel,pen,rsp_valid,cmd_ready=%b expected 0001",
                            {PSELx, PENABLE, rsp_valid, cmd_ready});
      end
      PREADY = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge PCLK);
         if (rsp_valid || PSELx) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_response: got activity=%b expected 0", seen);
      end
   endtask

   task automatic test_zero_wait_write();
      obs_t o;
      drive_xfer(1'b1, 32'h0000_0004, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0, o);
      n_checks++;
      if (o.ok_accept !== 1'b1) begin n_fail++; $display("FAIL zw_accept: got %b expected 1", o.ok_accept); end
      n_checks++;
      if ({o.setup, o.access} !== {32'd1, 32'd1}) begin
         n_fail++; $display("FAIL zw_phases: got setup=%0d access=%0d expected 1/1", o.setup, o.access);
      end
      n_checks++;
      if (o.latency !== 3) begin n_fail++; $display("FAIL zw_latency: got %0d expected 3", o.latency); end
      n_checks++;
      if ({o.stable, o.pen_bad} !== 2'b10) begin
         n_fail++; $display("FAIL zw_bus: got stable=%b pen_bad=%b expected 1/0", o.stable, o.pen_bad);
      end
      n_checks++;
      if ({o.rdata, o.err, o.tmo} !== {32'h0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL zw_rsp: got rdata=%h err=%b tmo=%b expected 0/0/0", o.rdata, o.err, o.tmo);
      end
      n_checks++;
      if ({o.bus_at_rsp, o.cmdrdy_at_rsp} !== 3'b000) begin
         n_fail++; $display("FAIL zw_resp_state: got bus=%b cmd_ready=%b expected 00/0", o.bus_at_rsp, o.cmdrdy_at_rsp);
      end
      consume(0);
   endtask

   task automatic test_wait_read();
      obs_t o;
      drive_xfer(1'b0, 32'h0000_0008, 32'h1234_5678, 3, 32'h0000_0041, 1'b0, o);
      n_checks++;
      if (o.access !== 4) begin n_fail++; $display("FAIL wr_access: got %0d expected 4", o.access); end
      n_checks++;
      if (o.latency !== 6) begin n_fail++; $display("FAIL wr_latency: got %0d expected 6", o.latency); end
      n_checks++;
      if (o.stable !== 1'b1) begin n_fail++; $display("FAIL wr_paddr_stable: got %b expected 1", o.stable); end
      n_checks++;
      if ({o.rdata, o.err, o.tmo} !== {32'h41, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL wr_rsp: got rdata=%h err=%b tmo=%b expected 41/0/0", o.rdata, o.err, o.tmo);
      end
      consume(1);
   endtask

   task automatic test_slave_error();
      obs_t o;
      drive_xfer(1'b1, 32'h0000_000C, 32'h0000_0077, 1, 32'hFFFF_FFFF, 1'b1, o);
      n_checks++;
      if ({o.rdata, o.err, o.tmo} !== {32'h0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL slverr_rsp: got rdata=%h err=%b tmo=%b expected 0/1/0", o.rdata, o.err, o.tmo);
      end
      consume(0);
   endtask

   task automatic test_timeout();
      obs_t o;
      drive_xfer(1'b0, 32'h0000_0020, 32'h0, 1000, 32'hAAAA_5555, 1'b0, o);
      n_checks++;
      if (o.access !== TMO) begin n_fail++; $display("FAIL tmo_access: got %0d expected %0d", o.access, TMO); end
      n_checks++;
      if (o.latency !== 2 + TMO) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", o.latency, 2 + TMO); end
      n_checks++;
      if (o.bus_at_rsp !== 2'b00) begin n_fail++; $display("FAIL tmo_bus_drop: got %b expected 00", o.bus_at_rsp); end
      n_checks++;
      if ({o.rdata, o.err, o.tmo} !== {32'h0, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL tmo_rsp: got rdata=%h err=%b tmo=%b expected 0/1/1", o.rdata, o.err, o.tmo);
      end
      consume(0);
   endtask

   task automatic test_backpressure();
      obs_t        o;
      logic [33:0] snap;
      logic        stable, leak;
      int          got;
      drive_xfer(1'b0, 32'h0000_0030, 32'h0, 1, 32'h0BAD_F00D, 1'b1, o);
      n_checks++;
      if ({o.latency, o.rdata, o.err} !== {32'd4, 32'h0BAD_F00D, 1'b1}) begin
         n_fail++; $display("FAIL bp_first: got lat=%0d rdata=%h err=%b expected 4/0badf00d/1", o.latency, o.rdata, o.err);
      end
      snap = {o.rdata, o.err, o.tmo};
      stable = 1'b1; leak = 1'b0;
      repeat (5) begin
         @(negedge PCLK);
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0044; cmd_wdata = 32'h0000_0099; rsp_ready = 1'b0;
         #1;
         if (!rsp_valid || {rsp_rdata, rsp_err, rsp_timeout} !== snap) stable = 1'b0;
         if (cmd_ready || PSELx) leak = 1'b1;
      end
      n_checks++;
      if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_stable: got %b expected 1", stable); end
      n_checks++;
      if (leak !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_blocked: got %b expected 0", leak); end
      @(negedge PCLK);
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_cmd_ready: got %b expected 1", cmd_ready); end
      @(posedge PCLK);
      #1 rsp_ready = 1'b0; cmd_valid = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0;
      @(negedge PCLK);
      n_checks++;
      if ({PSELx, PENABLE, rsp_valid, PADDR, PWDATA} !== {3'b100, 32'h44, 32'h99}) begin
         n_fail++; $display("FAIL bp_next_setup: got psel=%b pen=%b rv=%b paddr=%h expected 1/0/0/44",
                            PSELx, PENABLE, rsp_valid, PADDR);
      end
      got = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge PCLK);
         if (rsp_valid) begin got = 1; break; end
      end
      n_checks++;
      if ({got[0], rsp_rdata, rsp_err} !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++; $display("FAIL bp_second_rsp: got seen=%0d rdata=%h err=%b expected 1/0/0", got, rsp_rdata, rsp_err);
      end
      consume(0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs[3];
      logic        wrs[3];
      int          idx, nrsp, start, fin;
      idx = 0; nrsp = 0; start = -1; fin = -1;
      for (int i = 0; i < 3; i++) begin
         addrs[i] = $urandom & 32'hFFFF_FFFC;
         wrs[i]   = (i == 1);
      end
      rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
      for (int k = 0; k < 40 && nrsp < 3; k++) begin
         @(negedge PCLK);
         if (idx < 3) begin
            cmd_valid = 1'b1; cmd_write = wrs[idx]; cmd_addr = addrs[idx]; cmd_wdata = ~addrs[idx];
         end else begin
            cmd_valid = 1'b0;
         end
         PRDATA = slave_data(PADDR);
         #1;
         if (rsp_valid) begin
            n_checks++;
            if ({rsp_rdata, rsp_err} !== {(wrs[nrsp] ? 32'h0 : slave_data(addrs[nrsp])), 1'b0}) begin
               n_fail++; $display("FAIL b2b_rsp%0d: got rdata=%h err=%b expected %h/0", nrsp, rsp_rdata, rsp_err,
                                  wrs[nrsp] ? 32'h0 : slave_data(addrs[nrsp]));
            end
            nrsp++;
            if (nrsp == 3) fin = k;
         end
         if (cmd_valid && cmd_ready) begin
            if (idx == 0) start = k;
            idx++;
         end
      end
      n_checks++;
      if (fin - start !== 9 || start < 0) begin
         n_fail++; $display("FAIL b2b_throughput: got %0d cycles expected 9", fin - start);
      end
      @(negedge PCLK);
      cmd_valid = 1'b0; rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      obs_t        o;
      logic        wr, serr, exp_tmo, exp_err;
      logic [31:0] a, d, prd, exp_rd;
      int          waits, exp_acc;
      for (int n = 0; n < 30; n++) begin
         wr = 1'($urandom); serr = 1'($urandom); a = $urandom; d = $urandom; prd = $urandom;
         waits = $urandom_range(0, 6);
         exp_tmo = (waits >= TMO);
         exp_acc = exp_tmo ? TMO : waits + 1;
         exp_err = exp_tmo ? 1'b1 : serr;
         exp_rd  = (exp_tmo || wr) ? 32'h0 : prd;
         drive_xfer(wr, a, d, waits, prd, serr, o);
         n_checks++;
         if ({o.latency, o.access, o.setup} !== {2 + exp_acc, exp_acc, 32'd1}) begin
            n_fail++; $display("FAIL rnd%0d_timing: got lat=%0d acc=%0d setup=%0d expected %0d/%0d/1",
                               n, o.latency, o.access, o.setup, 2 + exp_acc, exp_acc);
         end
         n_checks++;
         if ({o.rdata, o.err, o.tmo} !== {exp_rd, exp_err, exp_tmo}) begin
            n_fail++; $display("FAIL rnd%0d_rsp: got rdata=%h err=%b tmo=%b expected %h/%b/%b",
                               n, o.rdata, o.err, o.tmo, exp_rd, exp_err, exp_tmo);
         end
         n_checks++;
         if ({o.stable, o.pen_bad, o.bus_at_rsp} !== 4'b1000) begin
            n_fail++; $display("FAIL rnd%0d_bus: got stable=%b pen_bad=%b bus=%b expected 1/0/00",
                               n, o.stable, o.pen_bad, o.bus_at_rsp);
         end
         consume($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait_write();
      test_wait_read();
      test_slave_error();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator: converts a simple valid/ready command stream into single APB transfers toward an APB responder such as the UART register block.
- Returns read data, error and timeout status on a valid/ready response channel.
- Sits between the bus-driving logic (CPU shim or test sequencer) and the PCLK-domain peripheral bus; at most one transfer outstanding.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data.
- ADDR_WIDTH, 32, width of PADDR and command address.
- TIMEOUT_CYCLES, 256, max ACCESS-phase cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (PRESET high at a rising edge):
  - state=IDLE; all outputs 0 (PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_*); timeout counter cleared.
  - Reset mid-transfer abandons the transfer: PSELx/PENABLE low after that edge, no response issued.
- All APB and rsp outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - cmd_ready = (state==IDLE) || (state==RESP && rsp_ready), combinational.
- IDLE: PSELx=0, PENABLE=0.
  - On cmd_valid&&cmd_ready, latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0; then ACCESS.
- ACCESS: PSELx=1, PENABLE=1.
  - PREADY=1: complete. Capture rsp_rdata=PRDATA for reads (0 for writes), rsp_err=PSLVERR, rsp_timeout=0, rsp_valid=1; go to RESP; PSELx/PENABLE low next cycle.
  - PREADY=0: increment timeout counter.
  - Timeout: if TIMEOUT_CYCLES>0 and PREADY has been low for TIMEOUT_CYCLES consecutive ACCESS cycles, go to RESP at the edge closing the TIMEOUT_CYCLES-th cycle with rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSELx/PENABLE drop.
  - Counter clears on entry to SETUP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready.
  - rsp_ready without an accepted command: rsp_valid=0, go to IDLE.
  - rsp_ready with cmd_valid: accept the new command in the same cycle and go directly to SETUP (back-to-back).
- PADDR, PWRITE, PWDATA:
  - Stable from SETUP through the end of ACCESS.
  - Hold their last values in IDLE/RESP; change only on command acceptance.
- Latency: acceptance edge N gives SETUP in cycle N+1 and ACCESS in N+2. With PREADY=1 in N+2, rsp_valid is high in N+3. Each PREADY wait state adds 1 cycle.
- Maximum throughput: 1 transfer per 3 cycles with zero wait states and rsp_ready held high.
- PRDATA/PSLVERR are sampled only in ACCESS with PREADY=1; ignored otherwise.

Test Plan:
- Reset: assert PRESET for 2 cycles mid-ACCESS -> PSELx=0, PENABLE=0, rsp_valid=0, cmd_ready=1 after release; no response for the aborted transfer.
- Zero-wait write: cmd write addr 0x0000_0004, data 0x0000_00A5, PREADY tied 1 -> PSELx high 2 cycles (PENABLE only in 2nd), PWDATA=0xA5, rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
- Wait-state read: read addr 0x0000_0008, PREADY low 3 ACCESS cycles, then high with PRDATA=0x0000_0041 -> ACCESS lasts 4 cycles, PADDR stable throughout, rsp_rdata=0x41.
- Slave error: write with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> exactly 4 ACCESS cycles, then PSELx=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Backpressure/back-to-back:
  - rsp_ready low for 5 cycles -> rsp_* stable, cmd_ready=0.
  - Then raise rsp_ready with cmd_valid high -> next SETUP begins on the following cycle; 3 commands complete in 9 cycles with rsp_ready=1.
